// File: rtl/sequencer_scheduler_pkg.sv
// sched_pkg: shared constants and types for the sequencer scheduler slice.
//   - default channel count and ROM address/data widths
//   - tick FSM state encoding (2-bit, legacy-compatible constants)
//   - tick_terminal(): terminal count of the tick counter, clamped so that
//     every channel strobe of a tick fits inside one tick period
package sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int TICK_W     = 16;

  typedef logic [1:0] tick_state_t;

  localparam tick_state_t ST_IDLE   = 2'd0;
  localparam tick_state_t ST_COUNT  = 2'd1;
  localparam tick_state_t ST_STROBE = 2'd2;

  // The strobe burst lasts NUM_CH cycles, so the period never drops below that.
  function automatic logic [TICK_W-1:0] tick_terminal(input logic [TICK_W-1:0] div,
                                                      input int num_ch);
    logic [TICK_W-1:0] floor_v;
    floor_v = TICK_W'(num_ch - 1);
    return (div > floor_v) ? div : floor_v;
  endfunction

endpackage

// File: rtl/sequencer_scheduler_if.sv
// sequencer_scheduler_if: request/grant/response bus between the sequencer
// array and the scheduler, plus the song ROM read port.
//   i_req       per-channel read request, held until granted
//   i_req_addr  per-channel ROM address, channel k at [k*ADDR_W +: ADDR_W]
//   o_gnt       one-hot grant (combinational)
//   o_rsp_valid one-hot response valid, one cycle after the grant
//   o_rsp_data  ROM data for the responding channel
//   o_rom_en    ROM read enable
//   o_rom_addr  ROM address
//   i_rom_data  ROM read data, one cycle after o_rom_en
// Modport slave is the scheduler side, master the sequencer/ROM side.
interface sequencer_scheduler_if import sched_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [NUM_CH-1:0]        i_req;
  logic [NUM_CH*ADDR_W-1:0] i_req_addr;
  logic [NUM_CH-1:0]        o_gnt;
  logic [NUM_CH-1:0]        o_rsp_valid;
  logic [DATA_W-1:0]        o_rsp_data;
  logic                     o_rom_en;
  logic [ADDR_W-1:0]        o_rom_addr;
  logic [DATA_W-1:0]        i_rom_data;

  modport slave (
    input  i_req, i_req_addr, i_rom_data,
    output o_gnt, o_rsp_valid, o_rsp_data, o_rom_en, o_rom_addr
  );

  modport master (
    output i_req, i_req_addr, i_rom_data,
    input  o_gnt, o_rsp_valid, o_rsp_data, o_rom_en, o_rom_addr
  );

endinterface

// File: rtl/sequencer_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over NUM_CH requesters.
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (pointer to 0, grant forced low)
//   i_req    request vector
//   o_gnt    one-hot grant: first request at or after the pointer
// The pointer moves to one past the granted channel and holds when idle.
module rr_arbiter import sched_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_gnt
);

  localparam int PW = $clog2(NUM_CH);

  logic [PW-1:0]     ptr;
  logic [NUM_CH-1:0] gnt_c;
  logic [PW-1:0]     gnt_idx;
  logic              found;

  always_comb begin
    int            k;
    logic [PW-1:0] idx;
    k       = 0;
    idx     = '0;
    gnt_c   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      idx = PW'(k);
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Grant is combinational, so reset must mask it to keep all outputs low.
  assign o_gnt = i_rst_n ? gnt_c : '0;

endmodule

// File: rtl/sequencer_scheduler.sv
// sequencer_scheduler: tempo tick generator with staggered per-channel note
// strobes, plus a round-robin shared song-ROM read scheduler.
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_enable    tick generator run/stop (arbiter always runs)
//   i_tick_div  tick period minus one, clamped to at least NUM_CH-1
//   o_tick      one-cycle tick pulse
//   o_note_stb  per-channel strobe, channel k k+1 cycles after o_tick
//   bus         request/grant/response and ROM port (slave side)
module sequencer_scheduler import sched_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [TICK_W-1:0]    i_tick_div,
  output logic                 o_tick,
  output logic [NUM_CH-1:0]    o_note_stb,
  sequencer_scheduler_if.slave bus
);

  localparam int IW = $clog2(NUM_CH);

  tick_state_t       state;
  logic [TICK_W-1:0] cnt;
  logic [IW-1:0]     stb_idx;
  logic [TICK_W-1:0] term;
  logic              at_term;

  assign term    = tick_terminal(i_tick_div, NUM_CH);
  assign at_term = (cnt == term);

  // The counter keeps running through STROBE so the tick period is exactly
  // term+1 regardless of the strobe burst; with the minimum period the next
  // tick lands on the last strobe and the burst restarts back-to-back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      stb_idx    <= '0;
      o_tick     <= 1'b0;
      o_note_stb <= '0;
    end else begin
      o_tick     <= 1'b0;
      o_note_stb <= '0;
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          stb_idx <= '0;
          if (i_enable) state <= ST_COUNT;
        end
        ST_COUNT, ST_STROBE: begin
          if (!i_enable) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            stb_idx <= '0;
          end else begin
            if (state == ST_STROBE) begin
              o_note_stb <= {{(NUM_CH-1){1'b0}}, 1'b1} << stb_idx;
            end
            if (at_term) begin
              o_tick  <= 1'b1;
              cnt     <= '0;
              stb_idx <= '0;
              state   <= ST_STROBE;
            end else begin
              cnt <= cnt + 1'b1;
              if (state == ST_STROBE) begin
                if (stb_idx == IW'(NUM_CH - 1)) begin
                  state   <= ST_COUNT;
                  stb_idx <= '0;
                end else begin
                  stb_idx <= stb_idx + 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // stage p0: grant and ROM address
  logic [NUM_CH-1:0] gnt_p0;
  logic [ADDR_W-1:0] rom_addr_p0;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (bus.i_req),
    .o_gnt   (gnt_p0)
  );

  always_comb begin
    rom_addr_p0 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_p0[k]) rom_addr_p0 = rom_addr_p0 | bus.i_req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign bus.o_gnt      = gnt_p0;
  assign bus.o_rom_en   = |gnt_p0;
  assign bus.o_rom_addr = rom_addr_p0;

  // stage p1: response, aligned with the ROM's one-cycle read latency
  logic [NUM_CH-1:0] vld_p1;
  logic [DATA_W-1:0] rsp_data_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= '0;
    end else begin
      vld_p1 <= gnt_p0;
    end
  end

  assign rsp_data_p1     = bus.i_rom_data;
  assign bus.o_rsp_valid = vld_p1;
  assign bus.o_rsp_data  = rsp_data_p1;

endmodule

// File: tb/tb_sequencer_scheduler.sv
// tb_sequencer_scheduler: directed and randomized bench for
// sequencer_scheduler (NUM_CH=4, ADDR_W=8, DATA_W=16) against a behavioural
// model of the tick schedule, round-robin order and ROM responses.
module tb_sequencer_scheduler;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_enable;
  logic [15:0] i_tick_div;
  logic        o_tick;
  logic [NUM_CH-1:0] o_note_stb;

  sequencer_scheduler_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sequencer_scheduler #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_tick_div (i_tick_div),
    .o_tick     (o_tick),
    .o_note_stb (o_note_stb),
    .bus        (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Song ROM: data = address * 2, one-cycle read latency.
  always @(posedge i_clk) begin
    if (bus.o_rom_en) bus.i_rom_data <= {{(DATA_W-ADDR_W){1'b0}}, bus.o_rom_addr} << 1;
  end

  int n_chk;
  int n_err;
  int cyc;
  int cyc_last;

  // model state
  int                m_p;
  bit                m_run;
  int                m_s;
  logic              exp_tick;
  logic [NUM_CH-1:0] exp_stb;
  logic [NUM_CH-1:0] exp_rv;
  logic [DATA_W-1:0] exp_rd;

  // last observed DUT values
  logic              obs_tick;
  logic [NUM_CH-1:0] obs_stb;
  logic [NUM_CH-1:0] obs_gnt;
  logic [NUM_CH-1:0] obs_rv;
  logic [DATA_W-1:0] obs_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_CH-1:0] model_gnt(input logic [NUM_CH-1:0] r, input int p);
    logic [NUM_CH-1:0] g;
    g = '0;
    for (int d = 0; d < NUM_CH; d++) begin
      if (g == '0 && r[(p + d) % NUM_CH]) g[(p + d) % NUM_CH] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_reset();
    m_p      = 0;
    m_run    = 0;
    m_s      = 0;
    exp_tick = 1'b0;
    exp_stb  = '0;
    exp_rv   = '0;
    exp_rd   = '0;
  endtask

  // Tick schedule: s counts edges since the edge that sampled enable in idle.
  // Ticks fall on s = P, 2P, ...; strobe k falls k+1 edges after a tick.
  task automatic model_tick_step();
    int tp;
    tp = (int'(i_tick_div) > NUM_CH - 1) ? int'(i_tick_div) + 1 : NUM_CH;
    if (!m_run) begin
      if (i_enable) begin
        m_run = 1;
        m_s   = 0;
      end
    end else if (!i_enable) begin
      m_run = 0;
    end else begin
      m_s++;
    end
    exp_tick = m_run && m_s > 0 && (m_s % tp) == 0;
    exp_stb  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (m_run && (m_s - k - 1) > 0 && ((m_s - k - 1) % tp) == 0) exp_stb[k] = 1'b1;
    end
  endtask

  // One clock: called just after a negedge with inputs already driven.
  task automatic cycle();
    logic [NUM_CH-1:0] eg;
    logic [ADDR_W-1:0] ea;
    int gk;
    #1;
    eg = i_rst_n ? model_gnt(bus.i_req, m_p) : '0;
    ea = '0;
    gk = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (eg[k]) begin
        ea = bus.i_req_addr[k*ADDR_W +: ADDR_W];
        gk = k;
      end
    end
    chk("gnt", 32'(bus.o_gnt), 32'(eg));
    chk("rom_en", 32'(bus.o_rom_en), 32'(|eg));
    chk("rom_addr", 32'(bus.o_rom_addr), 32'(ea));
    chk("tick", 32'(o_tick), 32'(exp_tick));
    chk("note_stb", 32'(o_note_stb), 32'(exp_stb));
    chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(exp_rv));
    if (exp_rv != '0) chk("rsp_data", 32'(bus.o_rsp_data), 32'(exp_rd));
    obs_tick = o_tick;
    obs_stb  = o_note_stb;
    obs_gnt  = bus.o_gnt;
    obs_rv   = bus.o_rsp_valid;
    obs_rd   = bus.o_rsp_data;
    cyc_last = cyc;
    cyc++;
    @(posedge i_clk);
    if (!i_rst_n) begin
      model_reset();
    end else begin
      if (gk >= 0) m_p = (gk + 1) % NUM_CH;
      exp_rv = eg;
      exp_rd = {{(DATA_W-ADDR_W){1'b0}}, ea} << 1;
      model_tick_step();
    end
    @(negedge i_clk);
  endtask

  task automatic wait_tick(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (obs_tick) begin
        at = cyc_last;
        break;
      end
    end
    if (at < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_tick: no tick within %0d cycles", limit);
    end
  endtask

  initial begin
    int t1, t2, c0;
    logic [NUM_CH-1:0] g_h  [6];
    logic [NUM_CH-1:0] rv_h [6];
    logic [DATA_W-1:0] rd_h [6];
    logic [NUM_CH-1:0] acc;

    n_chk = 0; n_err = 0; cyc = 0; cyc_last = 0;
    i_rst_n = 1'b0;
    i_enable = 1'b0;
    i_tick_div = 16'd9;
    bus.i_req = '0;
    bus.i_req_addr = '0;
    obs_gnt = '0;
    model_reset();
    @(negedge i_clk);

    // reset state
    cycle();
    cycle();
    chk("rst_tick", 32'(obs_tick), 32'd0);
    chk("rst_stb", 32'(obs_stb), 32'd0);
    chk("rst_rsp_valid", 32'(obs_rv), 32'd0);
    i_rst_n = 1'b1;

    // round robin with all four requesting, pointer starting at 0
    bus.i_req = 4'b1111;
    bus.i_req_addr = {8'h40, 8'h30, 8'h20, 8'h10};
    for (int i = 0; i < 6; i++) begin
      cycle();
      g_h[i] = obs_gnt; rv_h[i] = obs_rv; rd_h[i] = obs_rd;
    end
    chk("rr_g0", 32'(g_h[0]), 32'h1);
    chk("rr_g1", 32'(g_h[1]), 32'h2);
    chk("rr_g2", 32'(g_h[2]), 32'h4);
    chk("rr_g3", 32'(g_h[3]), 32'h8);
    chk("rr_g4", 32'(g_h[4]), 32'h1);
    chk("rr_v1", 32'(rv_h[1]), 32'h1);
    chk("rr_v4", 32'(rv_h[4]), 32'h8);
    chk("rr_d1", 32'(rd_h[1]), 32'h20);
    chk("rr_d2", 32'(rd_h[2]), 32'h40);
    chk("rr_d3", 32'(rd_h[3]), 32'h60);
    chk("rr_d4", 32'(rd_h[4]), 32'h80);

    // ch2 alone, then ch0 and ch3 together: ch3 first (pointer 3), then ch0
    bus.i_req = 4'b0100; cycle(); chk("solo_ch2", 32'(obs_gnt), 32'h4);
    bus.i_req = 4'b1001; cycle(); chk("pair_ch3", 32'(obs_gnt), 32'h8);
    bus.i_req = 4'b0001; cycle(); chk("pair_ch0", 32'(obs_gnt), 32'h1);
    bus.i_req = 4'b0000; cycle();

    // tick_div=9: period 10, staggered strobes
    i_tick_div = 16'd9;
    i_enable = 1'b1;
    c0 = cyc;
    wait_tick(40, t1);
    // enable is sampled at the end of cycle c0; the tick follows one period later
    chk("first_tick_delay", 32'(t1 - (c0 + 1)), 32'd10);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stb_seq9", 32'(obs_stb), 32'(4'b0001 << i));
    end
    wait_tick(40, t2);
    chk("period9", 32'(t2 - t1), 32'd10);

    // tick_div=1 clamps to a 4-cycle period, strobes back-to-back
    i_enable = 1'b0; cycle(); cycle();
    i_tick_div = 16'd1;
    i_enable = 1'b1;
    wait_tick(40, t1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stb_seq1", 32'(obs_stb), 32'(4'b0001 << i));
      if (i == 3) chk("clamp_tick", 32'(obs_tick), 32'd1);
    end
    cycle();
    chk("stb_wrap", 32'(obs_stb), 32'h1);

    // disable during the strobe burst, then re-enable
    i_enable = 1'b0; cycle(); cycle();
    i_tick_div = 16'd9;
    i_enable = 1'b1;
    wait_tick(40, t1);
    cycle();
    chk("drop_stb0", 32'(obs_stb), 32'h1);
    i_enable = 1'b0;
    cycle();
    chk("drop_stb1", 32'(obs_stb), 32'h2);
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      acc = acc | obs_stb | {3'b000, obs_tick};
    end
    chk("dropped_quiet", 32'(acc), 32'd0);
    i_enable = 1'b1;
    c0 = cyc;
    wait_tick(40, t1);
    chk("reenable_delay", 32'(t1 - (c0 + 1)), 32'd10);

    // reset asserted in the cycle of a grant
    i_enable = 1'b0;
    bus.i_req = 4'b1111;
    cycle(); cycle();
    #1;
    chk("pre_rst_gnt", 32'(|bus.o_gnt), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(bus.o_gnt), 32'd0);
    chk("rst_async_rom_en", 32'(bus.o_rom_en), 32'd0);
    chk("rst_async_rom_addr", 32'(bus.o_rom_addr), 32'd0);
    chk("rst_async_rv", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_async_tick", 32'({o_tick, o_note_stb}), 32'd0);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycle();
    chk("post_rst_rv", 32'(obs_rv), 32'd0);
    chk("post_rst_gnt", 32'(obs_gnt), 32'h1);
    cycle();
    chk("post_rst_rv_next", 32'(obs_rv), 32'h1);
    bus.i_req = '0;
    cycle();

    // randomized traffic with enable toggling
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.i_req[k] && obs_gnt[k]) begin
          if ($urandom_range(1, 0) == 1) bus.i_req_addr[k*ADDR_W +: ADDR_W] = 8'($urandom);
          else bus.i_req[k] = 1'b0;
        end else if (!bus.i_req[k] && $urandom_range(99, 0) < 35) begin
          bus.i_req[k] = 1'b1;
          bus.i_req_addr[k*ADDR_W +: ADDR_W] = 8'($urandom);
        end
      end
      if ($urandom_range(79, 0) == 0) i_enable = ~i_enable;
      if (!i_enable && $urandom_range(3, 0) == 0) i_tick_div = 16'($urandom_range(12, 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
